// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default widths and the
// slave-select width helper used by the master and the slave mux.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 32;
  localparam int APB_NUM_SLV = 4;

  // Number of top address bits that pick a slave; never below 1.
  function automatic int sel_width(input int num_slv);
    return (num_slv > 1) ? $clog2(num_slv) : 1;
  endfunction

endpackage

// File: rtl/apb_slv_mux.sv
// Combinational return-path mux: picks read data, ready and error of the
// slave addressed by a one-hot select; all outputs are 0 when nothing is selected.
module apb_slv_mux
  import apb_pkg::*;
#(
  parameter int NUM_SLV = APB_NUM_SLV,
  parameter int DATA_W  = APB_DATA_W
) (
  input  logic [NUM_SLV-1:0]        psel,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [DATA_W-1:0]         sel_rdata,
  output logic                      sel_ready,
  output logic                      sel_err
);

  logic [DATA_W-1:0] rdata_term [NUM_SLV];

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_term
      assign rdata_term[gi] = prdata[gi*DATA_W +: DATA_W] & {DATA_W{psel[gi]}};
    end
  endgenerate

  // AND-OR tree: relies on psel being one-hot or zero.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_rdata = sel_rdata | rdata_term[i];
    end
  end

  assign sel_ready = |(pready & psel);
  assign sel_err   = |(pslverr & psel);

endmodule

// File: rtl/apb_master_ws.sv
// APB master with wait states, slave error, address-decoded slave select and
// back-to-back chaining. Optional ACCESS timeout: define APB_MASTER_TIMEOUT_EN.
module apb_master_ws
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int NUM_SLV = APB_NUM_SLV
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic                      PCLK,
  input  logic                      Presetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        Psel,
  output logic                      Penable,
  output logic                      Pwrite,
  output logic [ADDR_W-1:0]         Paddr,
  output logic [DATA_W-1:0]         Pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] Prdata,
  input  logic [NUM_SLV-1:0]        Pready,
  input  logic [NUM_SLV-1:0]        Pslverr
);

  localparam int SEL_W = sel_width(NUM_SLV);

  apb_state_e          state_reg, state_next;
  logic [NUM_SLV-1:0]  psel_reg, psel_next;
  logic                penable_reg, penable_next;
  logic                pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0]   paddr_reg, paddr_next;
  logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready, sel_err;
  logic                accept;

  apb_slv_mux #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W)) u_slv_mux (
    .psel      (psel_reg),
    .prdata    (Prdata),
    .pready    (Pready),
    .pslverr   (Pslverr),
    .sel_rdata (sel_rdata),
    .sel_ready (sel_ready),
    .sel_err   (sel_err)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             timeout_hit;
  assign timeout_hit = (state_reg == ACCESS) && !sel_ready &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
`endif

  // A timeout only fires with sel_ready low, so it can never chain an accept.
  assign req_ready = (state_reg == IDLE) || ((state_reg == ACCESS) && sel_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next     = state_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_next  = wait_cnt_reg;
`endif
    case (state_reg)
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = sel_err;
          rsp_rdata_next = (!pwrite_reg && !sel_err) ? sel_rdata : '0;
          state_next     = IDLE;
          psel_next      = '0;
          penable_next   = 1'b0;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (timeout_hit) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
          state_next     = IDLE;
          psel_next      = '0;
          penable_next   = 1'b0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
`endif
      end
      default: ;
    endcase
    // A new command overrides the IDLE return of a completing transfer.
    if (accept) begin
      state_next   = SETUP;
      psel_next    = NUM_SLV'(1) << req_addr[ADDR_W-1 -: SEL_W];
      penable_next = 1'b0;
      pwrite_next  = req_write;
      paddr_next   = req_addr;
      pwdata_next  = req_write ? req_wdata : '0;
    end
  end

  always_ff @(posedge PCLK or negedge Presetn) begin
    if (!Presetn) begin
      state_reg     <= IDLE;
      psel_reg      <= '0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_reg  <= wait_cnt_next;
`endif
    end
  end

  assign Psel      = psel_reg;
  assign Penable   = penable_reg;
  assign Pwrite    = pwrite_reg;
  assign Paddr     = paddr_reg;
  assign Pwdata    = pwdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master_ws.sv
// Randomized bench for apb_master_ws: a transaction-level model predicts APB
// phases, req_ready and responses from each command's wait count and slave reply.
module tb_apb_master_ws;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NS = 4;

  logic             PCLK = 1'b0;
  logic             Presetn;
  logic             req_valid, req_ready, req_write;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_wdata;
  logic             rsp_valid, rsp_err;
  logic [DW-1:0]    rsp_rdata;
  logic [NS-1:0]    Psel;
  logic             Penable, Pwrite;
  logic [AW-1:0]    Paddr;
  logic [DW-1:0]    Pwdata;
  logic [NS*DW-1:0] Prdata;
  logic [NS-1:0]    Pready, Pslverr;

  apb_master_ws dut (
    .PCLK(PCLK), .Presetn(Presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    int            gap;
    logic [DW-1:0] rdata;
    logic          err;
  } cmd_t;

  cmd_t q[$];
  cmd_t cur;

  int n_chk = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Transaction-level expectations
  bit            act;
  int            cyc;      // 1 = SETUP, 2.. = ACCESS cycles of the current transfer
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_wdata;
  logic          m_rv;
  logic [DW-1:0] m_rd;
  logic          m_re;
  int            gap_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] slv_onehot(input logic [AW-1:0] a);
    int idx;
    idx = int'(a) / (2 ** (AW - $clog2(NS)));
    return NS'(1) << idx;
  endfunction

  function automatic int slv_idx(input logic [AW-1:0] a);
    return int'(a) / (2 ** (AW - $clog2(NS)));
  endfunction

  task automatic model_reset();
    act = 0; cyc = 0; m_addr = '0; m_wr = 0; m_wdata = '0;
    m_rv = 0; m_rd = '0; m_re = 0; gap_cnt = 0;
  endtask

  task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int waits, input int gap, input logic [DW-1:0] rd, input logic err);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = wd; c.waits = waits; c.gap = gap; c.rdata = rd; c.err = err;
    q.push_back(c);
  endtask

  task automatic step();
    bit present, complete, exp_ready, accept;
    int s;
    @(negedge PCLK);
    check("psel", 64'(Psel), 64'(act ? slv_onehot(cur.addr) : '0));
    check("penable", 64'(Penable), 64'(act && cyc >= 2));
    check("paddr", 64'(Paddr), 64'(m_addr));
    check("pwrite", 64'(Pwrite), 64'(m_wr));
    check("pwdata", 64'(Pwdata), 64'(m_wdata));
    check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    check("rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
    check("rsp_err", 64'(rsp_err), 64'(m_re));
    for (int i = 0; i < NS; i++) Prdata[i*DW +: DW] = $urandom;
    Pready  = NS'($urandom);
    Pslverr = NS'($urandom);
    complete = act && cyc >= 2 && (cyc - 2) == cur.waits;
    if (act && cyc >= 2) begin
      s = slv_idx(cur.addr);
      Pready[s] = complete;
      if (complete) begin
        Prdata[s*DW +: DW] = cur.rdata;
        Pslverr[s] = cur.err;
      end
    end
    present = (q.size() > 0) && (gap_cnt >= q[0].gap);
    if (present) begin
      req_valid = 1'b1; req_write = q[0].wr; req_addr = q[0].addr; req_wdata = q[0].wdata;
    end else begin
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
    end
    #1;
    exp_ready = !act || complete;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    accept = present && exp_ready;
    m_rv = complete;
    if (complete) begin
      m_re = cur.err;
      m_rd = (!cur.wr && !cur.err) ? cur.rdata : '0;
      n_txn++;
      $display("txn %0d: %s addr=%h wdata=%h waits=%0d -> rdata=%h err=%0d",
               n_txn, cur.wr ? "WR" : "RD", cur.addr, cur.wdata, cur.waits, m_rd, m_re);
    end
    if (accept) begin
      cur = q.pop_front();
      act = 1; cyc = 1; gap_cnt = 0;
      m_addr = cur.addr; m_wr = cur.wr; m_wdata = cur.wr ? cur.wdata : '0;
    end else begin
      gap_cnt++;
      if (complete) act = 0;
      else if (act) cyc++;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() > 0 || act) && guard < 20000) begin
      step();
      guard++;
    end
    check("drain_bound", 64'(guard >= 20000), 64'(0));
    step();
  endtask

  initial begin
    Presetn = 1'b0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    Prdata = '0; Pready = '0; Pslverr = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_psel", 64'(Psel), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_pwdata", 64'(Pwdata), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(1));
    Presetn = 1'b1;

    // Directed: zero-wait write, 3-wait read, back-to-back pair, error read
    push(1'b1, 8'h45, 32'hDEADBEEF, 0, 0, $urandom, 1'b0);
    push(1'b0, 8'hC0, 32'h0BADF00D, 3, 3, 32'h12345678, 1'b0);
    push(1'b1, 8'h10, 32'hA5A5A5A5, 0, 4, $urandom, 1'b0);
    push(1'b0, 8'h80, 32'h11111111, 0, 0, 32'hCAFEF00D, 1'b0);
    push(1'b0, 8'h9A, 32'h0, 1, 5, 32'hFFFFFFFF, 1'b1);
    drain();

    for (int n = 0; n < 150; n++)
      push(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 4),
           $urandom_range(0, 5), $urandom, ($urandom_range(0, 5) == 0));
    drain();

    // Asynchronous reset while the slave is inserting wait states
    push(1'b0, 8'h55, 32'h0, 6, 0, 32'h87654321, 1'b0);
    begin
      int guard;
      guard = 0;
      while (!(act && cyc == 4) && guard < 50) begin
        step();
        guard++;
      end
      check("reach_wait_bound", 64'(guard >= 50), 64'(0));
    end
    Presetn = 1'b0;
    req_valid = 1'b0;
    #1;
    check("arst_psel", 64'(Psel), 64'(0));
    check("arst_penable", 64'(Penable), 64'(0));
    check("arst_paddr", 64'(Paddr), 64'(0));
    check("arst_pwrite", 64'(Pwrite), 64'(0));
    check("arst_pwdata", 64'(Pwdata), 64'(0));
    check("arst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    q.delete();
    model_reset();
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    Presetn = 1'b1;
    repeat (5) step();

    push(1'b0, 8'hE7, 32'h0, 2, 1, 32'h5A5A1234, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
